// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified instruction/data memory port arbiter.
// Holds the default bus widths, FSM state encoding and requester owner ids.
package mips32_mem_pkg;

  localparam int unsigned MemAwDefault = 10;
  localparam int unsigned MemDwDefault = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StWait = WAIT,
    StResp = RESP
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter, grouped with modports.
// Performance counter signals exist only when MEM_PORT_ARBITER_PERF_EN is defined.
interface mem_port_arbiter_if
  import mips32_mem_pkg::*;
#(
  parameter int unsigned AW = MemAwDefault,
  parameter int unsigned DW = MemDwDefault
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0]   perf_if_gnt;
  logic [15:0]   perf_dm_gnt;
  logic [15:0]   perf_conflict;
`endif

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
`ifdef MEM_PORT_ARBITER_PERF_EN
    output perf_if_gnt, perf_dm_gnt, perf_conflict,
`endif
    output busy
  );

  // Requesters plus memory array side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
`ifdef MEM_PORT_ARBITER_PERF_EN
    input  perf_if_gnt, perf_dm_gnt, perf_conflict,
`endif
    input  busy
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data-side grants taken while fetch was waiting; once the
// count saturates at STARVE_MAX, force_if_o makes fetch win the next conflict.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic idle_i,
  input  logic if_req_i,
  input  logic if_win_i,
  input  logic dm_win_i,
  output logic force_if_o
);

  localparam logic [3:0] CntMax = 4'(STARVE_MAX);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_win_i) begin
      cnt_d = '0;
    end else if (dm_win_i && if_req_i) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 4'd1;
    end else if (idle_i && !if_req_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if_o = (cnt_q == CntMax);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter between instruction fetch and the data stage for one
// shared memory port. Optional perf counters: define MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
  import mips32_mem_pkg::*;
#(
  parameter int unsigned AW         = MemAwDefault,
  parameter int unsigned DW         = MemDwDefault,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic              clk1,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam logic [2:0] LatCnt = 3'(MEM_LAT);

  state_e        state_q, state_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;

  logic          idle, if_win, dm_win, force_if;

  logic          if_gnt_q, if_gnt_d;
  logic          dm_gnt_q, dm_gnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          owner_q, owner_d;
  logic          store_q, store_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;

  assign idle   = (state_q == StIdle);
  assign if_win = idle & bus.if_req & (~bus.dm_req | force_if);
  assign dm_win = idle & bus.dm_req & ~if_win;

  mem_arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk_i     (clk1),
    .rst_ni    (rst_n),
    .idle_i    (idle),
    .if_req_i  (bus.if_req),
    .if_win_i  (if_win),
    .dm_win_i  (dm_win),
    .force_if_o(force_if)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // WAIT covers the grant cycle through grant + MEM_LAT - 1; RESP samples mem_rdata.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (if_win || dm_win) begin
          state_d    = StWait;
          wait_cnt_d = 3'd1;
        end
      end
      StWait: begin
        if (wait_cnt_q == LatCnt) begin
          state_d    = StResp;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    owner_d     = owner_q;
    store_d     = store_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rvalid_d = 1'b0;
    dm_rdata_d  = dm_rdata_q;

    if (if_win) begin
      if_gnt_d    = 1'b1;
      mem_en_d    = 1'b1;
      mem_addr_d  = bus.if_addr;
      mem_wdata_d = '0;
      owner_d     = OWN_IF;
      store_d     = 1'b0;
    end else if (dm_win) begin
      dm_gnt_d    = 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = bus.dm_we;
      mem_addr_d  = bus.dm_addr;
      mem_wdata_d = bus.dm_wdata;
      owner_d     = OWN_DM;
      store_d     = bus.dm_we;
    end

    if (state_q == StResp) begin
      if (owner_q == OWN_IF) begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = bus.mem_rdata;
      end else begin
        dm_rvalid_d = 1'b1;
        dm_rdata_d  = store_q ? '0 : bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= OWN_IF;
      store_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      owner_q     <= owner_d;
      store_q     <= store_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state_q != StIdle);

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [15:0] perf_if_q, perf_dm_q, perf_cf_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      perf_if_q <= '0;
      perf_dm_q <= '0;
      perf_cf_q <= '0;
    end else begin
      if (if_win) perf_if_q <= sat_inc16(perf_if_q);
      if (dm_win) perf_dm_q <= sat_inc16(perf_dm_q);
      if (idle && bus.if_req && bus.dm_req) perf_cf_q <= sat_inc16(perf_cf_q);
    end
  end

  assign bus.perf_if_gnt   = perf_if_q;
  assign bus.perf_dm_gnt   = perf_dm_q;
  assign bus.perf_conflict = perf_cf_q;
`endif

endmodule
